// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: IF/ID register, one-entry decode-stall hold buffer, redirect squash
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_stage #(
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] pc_in,
    output logic              pcenable,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    input  logic              id_stall,
    input  logic              flush,
    output logic              ifid_valid,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_npc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] npc_q, npc_d;
    logic [WORD_W-1:0] hold_instr_q, hold_instr_d;
    logic [WORD_W-1:0] hold_npc_q, hold_npc_d;
    logic [WORD_W-1:0] pc_plus4;

    assign iaddr      = pc_in;
    assign ifid_valid = valid_q;
    assign ifid_instr = instr_q;
    assign ifid_npc   = npc_q;
    assign pc_plus4   = pc_in + WORD_W'(4);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        npc_d        = npc_q;
        hold_instr_d = hold_instr_q;
        hold_npc_d   = hold_npc_q;
        pcenable     = 1'b0;
        iREN         = 1'b0;
        if (RST) begin
            state_d = FETCH;
        end else if (flush) begin
            // PC must load the redirect target even though nothing is fetched
            pcenable     = 1'b1;
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            state_d      = FETCH;
            hold_instr_d = NOP_INSTR;
            hold_npc_d   = '0;
        end else begin
            case (state_q)
                FETCH: begin
                    iREN = 1'b1;
                    if (ihit) begin
                        pcenable = 1'b1;
                        if (id_stall) begin
                            hold_instr_d = iload;
                            hold_npc_d   = pc_plus4;
                            state_d      = HOLD;
                        end else begin
                            valid_d = 1'b1;
                            instr_d = iload;
                            npc_d   = pc_plus4;
                        end
                    end else if (!id_stall) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!id_stall) begin
                        valid_d = 1'b1;
                        instr_d = hold_instr_q;
                        npc_d   = hold_npc_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (pcenable && !flush && perf_fetched_q != 32'hFFFF_FFFF)
            perf_fetched_d = perf_fetched_q + 32'd1;
        if (((iREN && !ihit) || state_q == HOLD) && perf_stall_q != 32'hFFFF_FFFF)
            perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= FETCH;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            npc_q        <= '0;
            hold_instr_q <= NOP_INSTR;
            hold_npc_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            npc_q        <= npc_d;
            hold_instr_q <= hold_instr_d;
            hold_npc_q   <= hold_npc_d;
        end
    end

endmodule
